// File: rtl/imem_sync.sv
// ---------------------------------------------------------------------------
// imem_sync
//   Instruction memory for the fetch stage. The read port has a registered
//   response with one-cycle latency. A one-entry response register holds the
//   fetched word while decode stalls. A redirect flush discards the pending
//   response. Misaligned fetches return NOP_VALUE with an error flag. A
//   byte-enabled write port lets a loader program the array at run time.
//
// Ports
//   clk_i        clock; all state changes on the rising edge
//   rst_i        synchronous reset, active-high (response register only)
//   req_valid_i  fetch request valid
//   req_ready_o  fetch request accepted when valid & ready (combinational)
//   req_addr_i   fetch byte address
//   flush_i      drop pending response; block acceptance this cycle
//   rsp_valid_o  response register holds a valid instruction
//   rsp_ready_i  consumer takes the response when valid & ready
//   rsp_data_o   fetched instruction (registered)
//   rsp_err_o    fetch was misaligned; rsp_data_o carries NOP_VALUE
//   wr_en_i      program-port write strobe
//   wr_addr_i    program-port byte address (low OFF bits ignored)
//   wr_data_i    program-port write data
//   wr_be_i      byte enables; bit k writes wr_data_i[8k+7:8k]
// ---------------------------------------------------------------------------
module imem_sync #(
  parameter int          WIDTH     = 32,
  parameter int          IMEM_W    = 13,
  parameter              INIT_FILE = "",
  parameter logic [31:0] NOP_VALUE = 32'h13
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [IMEM_W-1:0]    req_addr_i,
  input  logic                 flush_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [WIDTH-1:0]     rsp_data_o,
  output logic                 rsp_err_o,
  input  logic                 wr_en_i,
  input  logic [IMEM_W-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0]     wr_data_i,
  input  logic [WIDTH/8-1:0]   wr_be_i
);

  localparam int BYTES = WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IDX_W = IMEM_W - OFF;
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP_VALUE);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  logic [WIDTH-1:0] mem_q [DEPTH];

  state_t           state_q;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic [IDX_W-1:0] req_idx, wr_idx;
  logic             req_misaligned;
  logic             accept;

  // Word indices take only the upper address bits, so they wrap modulo DEPTH.
  assign req_idx        = req_addr_i[IMEM_W-1:OFF];
  assign wr_idx         = wr_addr_i[IMEM_W-1:OFF];
  assign req_misaligned = (req_addr_i[OFF-1:0] != '0);

  // The write port ignores the byte-offset bits of its address.
  logic unused_wr_off;
  assign unused_wr_off = ^wr_addr_i[OFF-1:0];

  // A new request can enter when the slot is empty or is draining this
  // cycle. A flush always blocks entry, so the redirect wins over a fetch
  // that is already in progress.
  assign rsp_valid_o = (state_q == FULL);
  assign req_ready_o = !flush_i && (!rsp_valid_o || rsp_ready_i);
  assign accept      = req_valid_i && req_ready_o;

  // A misaligned fetch never looks at the array; it returns a NOP instead.
  always_comb begin
    rsp_err_d  = req_misaligned;
    rsp_data_d = req_misaligned ? NOP_W : mem_q[req_idx];
  end

  // --- response register / fetch FSM ---
  // Data and error are loaded only on accept, so they stay bit-stable
  // through a stall and after the slot drains.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= EMPTY;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (flush_i) begin
      state_q <= EMPTY;
    end else if (accept) begin
      state_q    <= FULL;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end else if (state_q == FULL && rsp_ready_i) begin
      state_q <= EMPTY;
    end
  end

  assign rsp_data_o = rsp_data_q;
  assign rsp_err_o  = rsp_err_q;

  // --- program port ---
  // The read above samples the array before this non-blocking update takes
  // effect. A read and a write to the same word at the same edge therefore
  // return the old contents.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int k = 0; k < BYTES; k++) begin
        if (wr_be_i[k]) mem_q[wr_idx][8*k +: 8] <= wr_data_i[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_imem_sync.sv
module tb_imem_sync;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [12:0] req_addr_i;
  logic        flush_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        wr_en_i;
  logic [12:0] wr_addr_i;
  logic [31:0] wr_data_i;
  logic [3:0]  wr_be_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  imem_sync #(.WIDTH(32), .IMEM_W(13), .INIT_FILE(""), .NOP_VALUE(32'h13)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .flush_i     (flush_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .wr_be_i     (wr_be_i)
  );

  // Advance past one rising edge; outputs are then sampled 1 ns later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [31:0] d, input logic e);
    chk({tag, "_valid"}, {31'b0, rsp_valid_o}, {31'b0, v});
    chk({tag, "_data"}, rsp_data_o, d);
    chk({tag, "_err"}, {31'b0, rsp_err_o}, {31'b0, e});
  endtask

  task automatic wr(input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d; wr_be_i = be;
    tick();
    wr_en_i = 1'b0; wr_be_i = 4'h0;
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; flush_i = 1'b0;
    rsp_ready_i = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0; wr_be_i = '0;
    @(negedge clk_i);
    tick();
    tick();
    rst_i = 1'b0;
    chk_rsp("reset", 1'b0, 32'h0, 1'b0);

    // Preload words 0..3
    wr(13'h000, 32'h11111111, 4'hF);
    wr(13'h004, 32'h22222222, 4'hF);
    wr(13'h008, 32'h33333333, 4'hF);
    wr(13'h00C, 32'h44444444, 4'hF);
    chk_rsp("after_preload", 1'b0, 32'h0, 1'b0);

    // Streaming fetch, one per cycle
    rsp_ready_i = 1'b1; req_valid_i = 1'b1; req_addr_i = 13'h000;
    settle();
    chk("ready_empty", {31'b0, req_ready_o}, 32'd1);
    tick(); chk_rsp("stream0", 1'b1, 32'h11111111, 1'b0);
    req_addr_i = 13'h004;
    settle();
    chk("ready_full_drain", {31'b0, req_ready_o}, 32'd1);
    tick(); chk_rsp("stream1", 1'b1, 32'h22222222, 1'b0);
    req_addr_i = 13'h008;
    tick(); chk_rsp("stream2", 1'b1, 32'h33333333, 1'b0);
    req_addr_i = 13'h00C;
    tick(); chk_rsp("stream3", 1'b1, 32'h44444444, 1'b0);
    req_valid_i = 1'b0;
    tick(); chk("drain_empty", {31'b0, rsp_valid_o}, 32'd0);

    // Stall: accept addr 4, then hold rsp_ready low for 3 cycles
    req_valid_i = 1'b1; req_addr_i = 13'h004;
    tick(); chk_rsp("stall_load", 1'b1, 32'h22222222, 1'b0);
    rsp_ready_i = 1'b0; req_addr_i = 13'h008;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_ready", {31'b0, req_ready_o}, 32'd0);
      tick();
      chk_rsp("stall_hold", 1'b1, 32'h22222222, 1'b0);
    end
    rsp_ready_i = 1'b1;
    settle();
    chk("release_ready", {31'b0, req_ready_o}, 32'd1);
    tick(); chk_rsp("release_next", 1'b1, 32'h33333333, 1'b0);

    // Misaligned fetch, then an aligned one clears the error
    req_addr_i = 13'h006;
    tick(); chk_rsp("misalign", 1'b1, 32'h00000013, 1'b1);
    req_addr_i = 13'h008;
    tick(); chk_rsp("realign", 1'b1, 32'h33333333, 1'b0);

    // Flush while FULL and stalled; a request during the flush is refused
    rsp_ready_i = 1'b0; flush_i = 1'b1; req_valid_i = 1'b1; req_addr_i = 13'h000;
    settle();
    chk("flush_ready", {31'b0, req_ready_o}, 32'd0);
    tick();
    chk("flush_valid", {31'b0, rsp_valid_o}, 32'd0);
    flush_i = 1'b0; rsp_ready_i = 1'b1; req_addr_i = 13'h008;
    tick(); chk_rsp("post_flush", 1'b1, 32'h33333333, 1'b0);

    // Read-before-write on the same word at the same edge
    req_addr_i = 13'h000;
    wr_en_i = 1'b1; wr_addr_i = 13'h000; wr_data_i = 32'hAABBCCDD; wr_be_i = 4'b0101;
    tick(); chk_rsp("rbw_old", 1'b1, 32'h11111111, 1'b0);
    wr_en_i = 1'b0; wr_be_i = 4'h0;
    tick(); chk_rsp("rbw_new", 1'b1, 32'h11BB11DD, 1'b0);

    // Write strobe with no byte enables changes nothing
    req_valid_i = 1'b0;
    wr(13'h004, 32'hFFFFFFFF, 4'h0);
    req_valid_i = 1'b1; req_addr_i = 13'h004;
    tick(); chk_rsp("be_zero", 1'b1, 32'h22222222, 1'b0);

    // Upper byte only, through a write address with nonzero offset bits
    req_valid_i = 1'b0;
    wr(13'h00F, 32'h99000000, 4'b1000);
    req_valid_i = 1'b1; req_addr_i = 13'h00C;
    tick(); chk_rsp("be_msb", 1'b1, 32'h99444444, 1'b0);

    // Reset while FULL and stalled; the memory is preserved
    req_addr_i = 13'h008;
    tick(); chk_rsp("pre_reset", 1'b1, 32'h33333333, 1'b0);
    rsp_ready_i = 1'b0; req_valid_i = 1'b0; rst_i = 1'b1;
    tick(); chk_rsp("reset_full", 1'b0, 32'h0, 1'b0);
    rst_i = 1'b0; rsp_ready_i = 1'b1; req_valid_i = 1'b1; req_addr_i = 13'h004;
    tick(); chk_rsp("mem_kept", 1'b1, 32'h22222222, 1'b0);
    req_valid_i = 1'b0;
    tick(); chk("final_empty", {31'b0, rsp_valid_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
